// File: rtl/modulation_config_scheduler.sv
// Configuration update sequencer for modulation_sampler: holds live CYCLE_M / FREQ_DIV_M / SEGMENT,
// commits a validated pending request immediately, at loop wrap, or at SYS_TIME, then masks settling.
module modulation_config_scheduler #(
  parameter logic [31:0] MinFreqDiv      = 32'd512,
  parameter int unsigned SettleCycles    = 134,
  parameter logic [15:0] DefaultCycleM   = 16'd1,
  parameter logic [31:0] DefaultFreqDivM = 32'd40960
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] SYS_TIME,
  input  logic [15:0] IDX,
  input  logic        UPDATE,
  input  logic [15:0] NEW_CYCLE_M,
  input  logic [31:0] NEW_FREQ_DIV_M,
  input  logic        NEW_SEGMENT,
  input  logic [1:0]  MODE,
  input  logic [63:0] TRANSITION_TIME,
  output logic [15:0] CYCLE_M,
  output logic [31:0] FREQ_DIV_M,
  output logic        SEGMENT,
  output logic        BUSY,
  output logic        SETTLING,
  output logic        DONE,
  output logic        ERR,
  output logic        LATE
);

  localparam int CntW = (SettleCycles > 2) ? $clog2(SettleCycles) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [15:0]     cycle_m, pend_cycle_m;
  logic [31:0]     freq_div_m, pend_freq_div_m;
  logic            segment, pend_segment;
  logic [1:0]      pend_mode;
  logic [63:0]     pend_time;
  logic [15:0]     idx_prev;
  logic [CntW-1:0] settle_cnt;
  logic            done, err, late;
  logic            accept, reject, commit;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (UPDATE) begin
          if (MODE == 2'd3 || NEW_FREQ_DIV_M < MinFreqDiv) begin
            reject = 1'b1;
          end else begin
            accept     = 1'b1;
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        reject = UPDATE;
        // A late MODE=2 target already satisfies the compare, so it commits on the first WAIT cycle.
        case (pend_mode)
          2'd0:    commit = 1'b1;
          2'd1:    commit = (idx_prev == cycle_m) && (IDX == 16'd0);
          2'd2:    commit = (SYS_TIME >= pend_time);
          default: commit = 1'b1;
        endcase
        if (commit) next_state = SETTLE;
      end
      SETTLE: begin
        reject = UPDATE;
        if (settle_cnt == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cycle_m         <= DefaultCycleM;
      freq_div_m      <= DefaultFreqDivM;
      segment         <= 1'b0;
      pend_cycle_m    <= DefaultCycleM;
      pend_freq_div_m <= DefaultFreqDivM;
      pend_segment    <= 1'b0;
      pend_mode       <= 2'd0;
      pend_time       <= '0;
      idx_prev        <= '0;
      settle_cnt      <= '0;
      done            <= 1'b0;
      err             <= 1'b0;
      late            <= 1'b0;
    end else begin
      idx_prev <= IDX;
      done     <= commit;
      err      <= reject;
      if (accept) begin
        pend_cycle_m    <= NEW_CYCLE_M;
        pend_freq_div_m <= NEW_FREQ_DIV_M;
        pend_segment    <= NEW_SEGMENT;
        pend_mode       <= MODE;
        pend_time       <= TRANSITION_TIME;
        late            <= (MODE == 2'd2) && (SYS_TIME >= TRANSITION_TIME);
      end
      if (commit) begin
        cycle_m    <= pend_cycle_m;
        freq_div_m <= pend_freq_div_m;
        segment    <= pend_segment;
        settle_cnt <= CntW'(SettleCycles - 1);
      end else if (state == SETTLE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
    end
  end

  assign CYCLE_M    = cycle_m;
  assign FREQ_DIV_M = freq_div_m;
  assign SEGMENT    = segment;
  assign BUSY       = (state != IDLE);
  assign SETTLING   = (state == SETTLE);
  assign DONE       = done;
  assign ERR        = err;
  assign LATE       = late;

endmodule
